alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit ALU.
- Decodes a MIPS instruction word into the ALU's 4-bit operation code and selects the two ALU operands: register data, sign-extended immediate or zero-extended immediate.
- Holds the result in a registered valid/ready output with a one-entry skid buffer, so the ALU side can stall without losing instructions.
- Counts stall cycles for performance debug.

Parameters:
- DATA_W, 32, operand width; must equal the ALU width.
- STALL_CNT_W, 16, width of the stall counter; saturates at the maximum value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  the instruction on the inputs is valid.
- in_ready  output  1  the stage accepts an instruction this cycle.
- instr  input  32  MIPS instruction word.
- rs_data  input  DATA_W  register file value for instr[25:21].
- rt_data  input  DATA_W  register file value for instr[20:16].
- out_valid  output  1  the ALU operands below are valid.
- out_ready  input  1  the ALU side consumes the output this cycle.
- alu_op  output  4  operation code to the ALU.
- alu_a  output  DATA_W  ALU operand a.
- alu_b  output  DATA_W  ALU operand b.
- illegal  output  1  the instruction did not decode.
- stall_cnt  output  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low on reset_n.
  - During reset: out_valid=0, alu_op=0, alu_a=0, alu_b=0, illegal=0, stall_cnt=0, skid entry empty, in_ready=0.
  - in_ready=1 from the first cycle after reset_n=1 while the skid entry is empty.
  - Reset asserted mid-stream drops both held entries; no partial instruction is emitted.
- Handshakes:
  - Input transfer when in_valid and in_ready are both 1. Output transfer when out_valid and out_ready are both 1.
  - Latency is 1 cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1.
- Storage states (output register OUT, skid register SKID):
  - EMPTY: OUT invalid. An accept loads OUT.
  - ONE: OUT valid, SKID empty.
    - Accept with out_ready=1: OUT is replaced.
    - Accept with out_ready=0: the new entry goes to SKID (state FULL).
  - FULL: in_ready=0. When OUT transfers, SKID moves to OUT (state ONE).
  - Simultaneous accept and transfer in ONE is a pass-through with no bubble.
  - in_ready is registered: it equals "SKID empty".
- Output stability: outputs hold stable while out_valid=1 and out_ready=0.
- Decoding is done on the input side, before the register; rs_data and rt_data are sampled in the accept cycle.
- Decode, R-type (opcode 0x00), by funct:
  - 0x24 AND -> op 0000; 0x25 OR -> 0001; 0x26 XOR -> 0010; 0x27 NOR -> 0011.
  - 0x21 ADDU -> 0100; 0x23 SUBU -> 0101; 0x20 ADD -> 0110; 0x22 SUB -> 0111.
  - 0x2A SLT -> 1100; 0x2B SLTU -> 1101.
  - For all of the above: a=rs, b=rt.
  - 0x04 SLLV -> 1001, a=rt, b={27'b0, rs[4:0]}.
  - 0x06 SRLV -> 1011, a=rt, b={27'b0, rs[4:0]}.
- Decode, SPECIAL2 (opcode 0x1C):
  - funct 0x21 CLO -> 1110; funct 0x20 CLZ -> 1111.
  - a=rs, b=0.
- Decode, I-type (a=rs):
  - 0x08 ADDI -> 0110, sign-extended immediate.
  - 0x09 ADDIU -> 0100, sign-extended immediate.
  - 0x0A SLTI -> 1100, sign-extended immediate.
  - 0x0B SLTIU -> 1101, sign-extended immediate.
  - 0x0C ANDI -> 0000, zero-extended immediate.
  - 0x0D ORI -> 0001, zero-extended immediate.
  - 0x0E XORI -> 0010, zero-extended immediate.
- Any other encoding: op 0000, a=0, b=0, illegal=1. It still flows through the handshake.
- stall_cnt increments by 1 per stall cycle and saturates at the all-ones value; it never wraps.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined:
  - Adds inputs wb_valid (1), wb_reg (5), wb_data (DATA_W).
  - At accept, if wb_valid=1, wb_reg!=0 and wb_reg equals instr[25:21], wb_data replaces rs_data.
  - The same rule applies independently to instr[20:16] and rt_data.
  - Register 0 is never forwarded.
- Not defined: the ports are absent and operands come only from rs_data and rt_data.

Decomposition:
- Shared package alu_pkg, holding:
  - ALU op-code localparams (OP_AND .. OP_CLZ);
  - MIPS opcode and funct constants;
  - a 4-bit alu_op_t typedef.
- One sub-module, alu_issue_decode: purely combinational; instr, rs, rt in; op, a, b, illegal out.
- alu_issue_stage holds only the OUT/SKID registers, the handshake and the counter.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 -> out_valid=0, stall_cnt=0, in_ready=0; after release, in_ready=1.
- ADDU: instr=0x00851021, rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, op=0100, a=5, b=7, illegal=0.
- Immediate extension:
  - ADDI with imm 0xFFFF, rs=3 -> op=0110, b=0xFFFFFFFF.
  - ORI with imm 0x8000 -> op=0001, b=0x00008000.
- Backpressure: send 3 back-to-back instructions with out_ready=0 -> two are held, in_ready=0 on the 3rd cycle, stall_cnt counts up; raise out_ready -> both emitted in order with no loss and no duplication.
- Illegal: instr=0xFC000000 -> op=0000, a=0, b=0, illegal=1. CLZ (0x70801020, rs=0x00F00000) -> op=1111, a=0x00F00000.
- With ALU_ISSUE_FWD_EN: wb_reg=4, wb_data=0xDEAD, rs field=4 -> a=0xDEAD. With wb_reg=0 -> no forwarding.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: ALU op codes and MIPS opcode/funct encodings.
package alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t OP_AND  = 4'b0000;
   localparam alu_op_t OP_OR   = 4'b0001;
   localparam alu_op_t OP_XOR  = 4'b0010;
   localparam alu_op_t OP_NOR  = 4'b0011;
   localparam alu_op_t OP_ADDU = 4'b0100;
   localparam alu_op_t OP_SUBU = 4'b0101;
   localparam alu_op_t OP_ADD  = 4'b0110;
   localparam alu_op_t OP_SUB  = 4'b0111;
   localparam alu_op_t OP_SLL  = 4'b1001;
   localparam alu_op_t OP_SRL  = 4'b1011;
   localparam alu_op_t OP_SLT  = 4'b1100;
   localparam alu_op_t OP_SLTU = 4'b1101;
   localparam alu_op_t OP_CLO  = 4'b1110;
   localparam alu_op_t OP_CLZ  = 4'b1111;

   localparam logic [5:0] OPC_RTYPE    = 6'h00;
   localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OPC_ADDI     = 6'h08;
   localparam logic [5:0] OPC_ADDIU    = 6'h09;
   localparam logic [5:0] OPC_SLTI     = 6'h0A;
   localparam logic [5:0] OPC_SLTIU    = 6'h0B;
   localparam logic [5:0] OPC_ANDI     = 6'h0C;
   localparam logic [5:0] OPC_ORI      = 6'h0D;
   localparam logic [5:0] OPC_XORI     = 6'h0E;

   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;
   localparam logic [5:0] FN_CLZ  = 6'h20;
   localparam logic [5:0] FN_CLO  = 6'h21;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode into ALU op code and operand selection.
module alu_issue_decode
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output alu_op_t           op,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              illegal
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_zext;
   logic [DATA_W-1:0] shamt;
   logic              unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign imm_sext      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
   assign imm_zext      = {{(DATA_W-16){1'b0}}, instr[15:0]};
   assign shamt         = {{(DATA_W-5){1'b0}}, rs[4:0]};
   assign unused_fields = ^instr[25:16];

   always_comb begin
      op      = OP_AND;
      a       = '0;
      b       = '0;
      illegal = 1'b0;
      case (opcode)
         OPC_RTYPE: begin
            a = rs;
            b = rt;
            case (funct)
               FN_AND:  op = OP_AND;
               FN_OR:   op = OP_OR;
               FN_XOR:  op = OP_XOR;
               FN_NOR:  op = OP_NOR;
               FN_ADDU: op = OP_ADDU;
               FN_SUBU: op = OP_SUBU;
               FN_ADD:  op = OP_ADD;
               FN_SUB:  op = OP_SUB;
               FN_SLT:  op = OP_SLT;
               FN_SLTU: op = OP_SLTU;
               FN_SLLV: begin op = OP_SLL; a = rt; b = shamt; end
               FN_SRLV: begin op = OP_SRL; a = rt; b = shamt; end
               default: begin a = '0; b = '0; illegal = 1'b1; end
            endcase
         end
         OPC_SPECIAL2: begin
            case (funct)
               FN_CLO:  begin op = OP_CLO; a = rs; end
               FN_CLZ:  begin op = OP_CLZ; a = rs; end
               default: illegal = 1'b1;
            endcase
         end
         OPC_ADDI:  begin op = OP_ADD;  a = rs; b = imm_sext; end
         OPC_ADDIU: begin op = OP_ADDU; a = rs; b = imm_sext; end
         OPC_SLTI:  begin op = OP_SLT;  a = rs; b = imm_sext; end
         OPC_SLTIU: begin op = OP_SLTU; a = rs; b = imm_sext; end
         OPC_ANDI:  begin op = OP_AND;  a = rs; b = imm_zext; end
         OPC_ORI:   begin op = OP_OR;   a = rs; b = imm_zext; end
         OPC_XORI:  begin op = OP_XOR;  a = rs; b = imm_zext; end
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, registered valid/ready output with one-entry skid, stall counter.
// Optional writeback forwarding into rs/rt is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            instr,
   input  logic [DATA_W-1:0]      rs_data,
   input  logic [DATA_W-1:0]      rt_data,
`ifdef ALU_ISSUE_FWD_EN
   input  logic                   wb_valid,
   input  logic [4:0]             wb_reg,
   input  logic [DATA_W-1:0]      wb_data,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3:0]             alu_op,
   output logic [DATA_W-1:0]      alu_a,
   output logic [DATA_W-1:0]      alu_b,
   output logic                   illegal,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int unsigned EntW = 4 + 2 * DATA_W + 1;

   logic [DATA_W-1:0] rs_sel;
   logic [DATA_W-1:0] rt_sel;
   alu_op_t           dec_op;
   logic [DATA_W-1:0] dec_a;
   logic [DATA_W-1:0] dec_b;
   logic              dec_illegal;
   logic [EntW-1:0]   dec_entry;

   logic [EntW-1:0]        out_q, out_d;
   logic                   out_valid_q, out_valid_d;
   logic [EntW-1:0]        skid_q, skid_d;
   logic                   skid_valid_q, skid_valid_d;
   logic                   in_ready_q;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   accept;
   logic                   xfer;

`ifdef ALU_ISSUE_FWD_EN
   // $zero is never forwarded even if a writeback targets it.
   assign rs_sel = (wb_valid && wb_reg != 5'd0 && wb_reg == instr[25:21]) ? wb_data : rs_data;
   assign rt_sel = (wb_valid && wb_reg != 5'd0 && wb_reg == instr[20:16]) ? wb_data : rt_data;
`else
   assign rs_sel = rs_data;
   assign rt_sel = rt_data;
`endif

   alu_issue_decode #(
      .DATA_W (DATA_W)
   ) u_decode (
      .instr   (instr),
      .rs      (rs_sel),
      .rt      (rt_sel),
      .op      (dec_op),
      .a       (dec_a),
      .b       (dec_b),
      .illegal (dec_illegal)
   );

   assign dec_entry = {dec_op, dec_a, dec_b, dec_illegal};
   assign accept    = in_valid && in_ready_q;
   assign xfer      = out_valid_q && out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      stall_d      = stall_q;
      if (xfer || !out_valid_q) begin
         // OUT is free this cycle: refill from SKID first to keep order, else from input.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = dec_entry;
         end
      end else if (accept) begin
         skid_d       = dec_entry;
         skid_valid_d = 1'b1;
      end
      if (out_valid_q && !out_ready && !(&stall_q)) stall_d = stall_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         stall_q      <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
         stall_q      <= stall_d;
      end
   end

   assign in_ready                         = in_ready_q;
   assign out_valid                        = out_valid_q;
   assign {alu_op, alu_a, alu_b, illegal}  = out_q;
   assign stall_cnt                        = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (forwarding checks when ALU_ISSUE_FWD_EN is set).
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        illegal;
   logic [15:0] stall_cnt;
`ifdef ALU_ISSUE_FWD_EN
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg   = 5'd0;
   logic [31:0] wb_data  = 32'd0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_issue_stage u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
`ifdef ALU_ISSUE_FWD_EN
      .wb_valid  (wb_valid),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .illegal   (illegal),
      .stall_cnt (stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic ill);
      check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, ".op"}, 64'(alu_op), 64'(op));
      check_eq({tag, ".a"}, 64'(alu_a), 64'(a));
      check_eq({tag, ".b"}, 64'(alu_b), 64'(b));
      check_eq({tag, ".illegal"}, 64'(illegal), 64'(ill));
   endtask

   // Single accept with out_ready=1; outputs are checked right after the accepting edge.
   task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      instr     = ins;
      rs_data   = rs;
      rt_data   = rt;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      instr     = 32'h0085_1021;
      rs_data   = 32'd1;
      rt_data   = 32'd2;
      repeat (3) tick();
      check_eq("rst.out_valid", 64'(out_valid), 64'd0);
      check_eq("rst.in_ready", 64'(in_ready), 64'd0);
      check_eq("rst.stall", 64'(stall_cnt), 64'd0);
      check_eq("rst.op", 64'(alu_op), 64'd0);
      check_eq("rst.a", 64'(alu_a), 64'd0);
      reset_n  = 1'b1;
      in_valid = 1'b0;
      tick();
      check_eq("rel.in_ready", 64'(in_ready), 64'd1);
      check_eq("rel.out_valid", 64'(out_valid), 64'd0);

      send(32'h0085_1021, 32'd5, 32'd7);
      check_out("addu", 4'b0100, 32'd5, 32'd7, 1'b0);
      send(32'h2021_FFFF, 32'd3, 32'd9);
      check_out("addi", 4'b0110, 32'd3, 32'hFFFF_FFFF, 1'b0);
      send(32'h3400_8000, 32'h12, 32'd0);
      check_out("ori", 4'b0001, 32'h12, 32'h0000_8000, 1'b0);
      send(32'h0085_1004, 32'h123, 32'hABCD);
      check_out("sllv", 4'b1001, 32'hABCD, 32'h3, 1'b0);
      send(32'h0085_1022, 32'd10, 32'd4);
      check_out("sub", 4'b0111, 32'd10, 32'd4, 1'b0);
      send(32'hFC00_0000, 32'h55, 32'h66);
      check_out("illegal", 4'b0000, 32'd0, 32'd0, 1'b1);
      send(32'h0000_0000, 32'h55, 32'h66);
      check_out("rtype_bad", 4'b0000, 32'd0, 32'd0, 1'b1);
      send(32'h7080_1020, 32'h00F0_0000, 32'h77);
      check_out("clz", 4'b1111, 32'h00F0_0000, 32'd0, 1'b0);

`ifdef ALU_ISSUE_FWD_EN
      wb_valid = 1'b1;
      wb_reg   = 5'd4;
      wb_data  = 32'hDEAD;
      send(32'h0085_1021, 32'd5, 32'd7);
      check_out("fwd_rs", 4'b0100, 32'hDEAD, 32'd7, 1'b0);
      wb_reg = 5'd0;
      send(32'h0005_1021, 32'd5, 32'd7);
      check_out("fwd_r0", 4'b0100, 32'd5, 32'd7, 1'b0);
      wb_valid = 1'b0;
`endif

      // Drain, then three back-to-back offers against a stalled ALU.
      out_ready = 1'b1;
      tick();
      check_eq("drain.out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h0085_1021;  rs_data = 32'd1;  rt_data = 32'd2;
      tick();
      check_out("bp.a0", 4'b0100, 32'd1, 32'd2, 1'b0);
      check_eq("bp.rdy0", 64'(in_ready), 64'd1);
      instr     = 32'h0085_1022;  rs_data = 32'd10; rt_data = 32'd3;
      tick();
      check_eq("bp.rdy1", 64'(in_ready), 64'd0);
      check_eq("bp.stall1", 64'(stall_cnt), 64'd1);
      instr     = 32'h0085_1026;  rs_data = 32'hF0; rt_data = 32'h0F;
      tick();
      check_out("bp.hold", 4'b0100, 32'd1, 32'd2, 1'b0);
      check_eq("bp.rdy2", 64'(in_ready), 64'd0);
      check_eq("bp.stall2", 64'(stall_cnt), 64'd2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_out("bp.b", 4'b0111, 32'd10, 32'd3, 1'b0);
      check_eq("bp.rdy3", 64'(in_ready), 64'd1);
      tick();
      check_eq("bp.empty", 64'(out_valid), 64'd0);
      check_eq("bp.stall3", 64'(stall_cnt), 64'd2);

      // Pass-through: accept and transfer in the same cycle, no bubble.
      in_valid = 1'b1;
      instr    = 32'h0085_1024;  rs_data = 32'hFF; rt_data = 32'h0F;
      tick();
      instr    = 32'h0085_1025;  rs_data = 32'hA0; rt_data = 32'h05;
      tick();
      check_out("pt.or", 4'b0001, 32'hA0, 32'h05, 1'b0);
      check_eq("pt.rdy", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      tick();

      // Stall counter saturation.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      instr     = 32'h3400_0001;  rs_data = 32'd0;
      tick();
      in_valid = 1'b0;
      repeat (65540) tick();
      check_eq("sat.stall", 64'(stall_cnt), 64'hFFFF);
      check_out("sat.hold", 4'b0001, 32'd0, 32'd1, 1'b0);

      // Fill SKID, then reset mid-stream: both entries must vanish.
      in_valid = 1'b1;
      instr    = 32'h0085_1021;  rs_data = 32'd8; rt_data = 32'd9;
      tick();
      check_eq("mid.full", 64'(in_ready), 64'd0);
      reset_n = 1'b0;
      tick();
      check_eq("mid.out_valid", 64'(out_valid), 64'd0);
      check_eq("mid.stall", 64'(stall_cnt), 64'd0);
      reset_n   = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq("post.out_valid", 64'(out_valid), 64'd0);
      check_eq("post.in_ready", 64'(in_ready), 64'd1);
      tick();
      check_eq("post2.out_valid", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
